// File: rtl/capture_pkg.sv
// Shared types and defaults for the logic-analyser capture controller.
package capture_pkg;

   localparam int unsigned CH_W_DEF   = 8;
   localparam int unsigned ADDR_W_DEF = 13;
   localparam int unsigned DIV_W      = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CONFIG,
      ST_PRE,
      ST_WAIT_TRIG,
      ST_POST,
      ST_DONE
   } state_t;

   // States in which an acquisition is in progress.
   function automatic logic is_busy(input state_t s);
      return (s == ST_CONFIG) || (s == ST_PRE) || (s == ST_WAIT_TRIG) || (s == ST_POST);
   endfunction

endpackage

// File: rtl/capture_trig_match.sv
// Mask/value trigger comparator, qualified by the sample strobe and the trigger-search window.
module capture_trig_match
   import capture_pkg::*;
#(
   parameter int unsigned CH_W = CH_W_DEF
) (
   input  logic [CH_W-1:0] i_probe,
   input  logic [CH_W-1:0] i_mask,
   input  logic [CH_W-1:0] i_val,
   input  logic            i_sample_en,
   input  logic            i_enable,
   output logic            o_match_c
);

   logic w_level_ok;

   // Unmasked channels are don't-care; masked channels must equal the required level.
   assign w_level_ok = (((i_probe ^ i_val) & i_mask) == '0);
   assign o_match_c  = i_enable & i_sample_en & w_level_ok;

endmodule

// File: rtl/capture_controller.sv
// Sequences one acquisition: divider load, pre-trigger fill, ring write while
// searching for the trigger, post-trigger fill, then done.
module capture_controller
   import capture_pkg::*;
#(
   parameter int unsigned CH_W   = CH_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              arm,
   input  logic              abort,
   input  logic [DIV_W-1:0]  cfg_divider,
   input  logic [ADDR_W-1:0] cfg_pre,
   input  logic [ADDR_W-1:0] cfg_post,
   input  logic [CH_W-1:0]   cfg_trig_mask,
   input  logic [CH_W-1:0]   cfg_trig_val,
   input  logic [CH_W-1:0]   probe,
   input  logic              sample_en,
   output logic [DIV_W-1:0]  div_value,
   output logic              div_update,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [CH_W-1:0]   wr_data,
   output logic              busy,
   output logic              triggered,
   output logic              done,
   output logic [ADDR_W-1:0] trig_addr,
   output logic [ADDR_W-1:0] start_addr
);

   state_t              r_state;
   state_t              w_next_state;
   logic [ADDR_W-1:0]   r_ptr;
   logic [ADDR_W-1:0]   r_cnt;
   logic [ADDR_W-1:0]   r_pre;
   logic [ADDR_W-1:0]   r_post;
   logic [CH_W-1:0]     r_mask;
   logic [CH_W-1:0]     r_val;
   logic [ADDR_W-1:0]   w_cnt_inc;
   logic                w_match_c;
   logic                w_enter_cfg;
   logic                w_take;
   logic                w_trig;

   assign w_cnt_inc = r_cnt + ADDR_W'(1);

   capture_trig_match #(
      .CH_W (CH_W)
   ) u_trig_match (
      .i_probe     (probe),
      .i_mask      (r_mask),
      .i_val       (r_val),
      .i_sample_en (sample_en),
      .i_enable    (r_state == ST_WAIT_TRIG),
      .o_match_c   (w_match_c)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state plus datapath strobes; abort always wins over arm and sampling.
   always_comb begin
      w_next_state = r_state;
      w_enter_cfg  = 1'b0;
      w_take       = 1'b0;
      w_trig       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (arm && !abort) begin
               w_next_state = ST_CONFIG;
               w_enter_cfg  = 1'b1;
            end
         end
         ST_CONFIG: begin
            if (abort) begin
               w_next_state = ST_IDLE;
            end else if (r_pre == '0) begin
               w_next_state = ST_WAIT_TRIG;
            end else begin
               w_next_state = ST_PRE;
            end
         end
         ST_PRE: begin
            if (abort) begin
               w_next_state = ST_IDLE;
            end else if (sample_en) begin
               w_take = 1'b1;
               if (w_cnt_inc == r_pre) begin
                  w_next_state = ST_WAIT_TRIG;
               end
            end
         end
         ST_WAIT_TRIG: begin
            if (abort) begin
               w_next_state = ST_IDLE;
            end else if (sample_en) begin
               w_take = 1'b1;
               if (w_match_c) begin
                  w_trig       = 1'b1;
                  w_next_state = (r_post <= ADDR_W'(1)) ? ST_DONE : ST_POST;
               end
            end
         end
         ST_POST: begin
            if (abort) begin
               w_next_state = ST_IDLE;
            end else if (sample_en) begin
               w_take = 1'b1;
               if (w_cnt_inc == r_post) begin
                  w_next_state = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (abort) begin
               w_next_state = ST_IDLE;
            end else if (arm) begin
               w_next_state = ST_CONFIG;
               w_enter_cfg  = 1'b1;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Config latch, write pointer/counter and registered outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ptr      <= '0;
         r_cnt      <= '0;
         r_pre      <= '0;
         r_post     <= '0;
         r_mask     <= '0;
         r_val      <= '0;
         div_value  <= '0;
         div_update <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         triggered  <= 1'b0;
         trig_addr  <= '0;
         start_addr <= '0;
      end else begin
         div_update <= w_enter_cfg;
         wr_en      <= w_take;
         busy       <= is_busy(w_next_state);
         done       <= (w_next_state == ST_DONE);
         if (w_enter_cfg) begin
            div_value <= cfg_divider;
            r_pre     <= cfg_pre;
            r_post    <= cfg_post;
            r_mask    <= cfg_trig_mask;
            r_val     <= cfg_trig_val;
            r_ptr     <= '0;
            r_cnt     <= '0;
            triggered <= 1'b0;
         end
         if (w_take) begin
            wr_addr <= r_ptr;
            wr_data <= probe;
            r_ptr   <= r_ptr + ADDR_W'(1);
            r_cnt   <= w_trig ? ADDR_W'(1) : w_cnt_inc;
         end
         // The trigger sample opens the post window and anchors the readout.
         if (w_trig) begin
            trig_addr  <= r_ptr;
            start_addr <= r_ptr - r_pre;
            triggered  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_capture_controller.sv
// Bench for capture_controller: directed scenarios plus randomized acquisitions,
// checked every cycle against a sample-level behavioural model.
module tb_capture_controller;

   localparam int CH    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int P_IDLE = 0, P_CFG = 1, P_PRE = 2, P_WAIT = 3, P_POST = 4, P_DONE = 5;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          arm = 1'b0;
   logic          abort = 1'b0;
   logic [31:0]   cfg_divider = '0;
   logic [AW-1:0] cfg_pre = '0;
   logic [AW-1:0] cfg_post = '0;
   logic [CH-1:0] cfg_trig_mask = '0;
   logic [CH-1:0] cfg_trig_val = '0;
   logic [CH-1:0] probe = '0;
   logic          sample_en = 1'b0;
   logic [31:0]   div_value;
   logic          div_update;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [CH-1:0] wr_data;
   logic          busy;
   logic          triggered;
   logic          done;
   logic [AW-1:0] trig_addr;
   logic [AW-1:0] start_addr;

   always #5 clk = ~clk;

   capture_controller #(.CH_W(CH), .ADDR_W(AW)) dut (
      .clk(clk), .resetn(resetn), .arm(arm), .abort(abort),
      .cfg_divider(cfg_divider), .cfg_pre(cfg_pre), .cfg_post(cfg_post),
      .cfg_trig_mask(cfg_trig_mask), .cfg_trig_val(cfg_trig_val),
      .probe(probe), .sample_en(sample_en),
      .div_value(div_value), .div_update(div_update),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .triggered(triggered), .done(done),
      .trig_addr(trig_addr), .start_addr(start_addr)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: acquisition phase, countdowns and expected outputs.
   int       ph = P_IDLE;
   int       m_ptr = 0, pre_left = 0, post_left = 0, l_pre = 0, l_post = 0;
   bit [7:0] l_mask = 0, l_val = 0;
   bit       e_wr_en = 0, e_div_upd = 0, e_trig = 0;
   int       e_wr_addr = 0, e_taddr = 0, e_start = 0;
   bit [7:0] e_wr_data = 0;
   bit [31:0] e_div_val = 0;

   task automatic model_reset();
      ph = P_IDLE; m_ptr = 0; pre_left = 0; post_left = 0;
      e_wr_en = 0; e_div_upd = 0; e_trig = 0; e_wr_addr = 0;
      e_taddr = 0; e_start = 0; e_wr_data = 0; e_div_val = 0;
   endtask

   task automatic model_step();
      int a;
      e_wr_en   = 0;
      e_div_upd = 0;
      if (abort) begin
         ph = P_IDLE;
      end else if (arm && (ph == P_IDLE || ph == P_DONE)) begin
         l_pre = int'(cfg_pre); l_post = int'(cfg_post);
         l_mask = cfg_trig_mask; l_val = cfg_trig_val;
         e_div_val = cfg_divider; e_div_upd = 1;
         m_ptr = 0; e_trig = 0; ph = P_CFG;
      end else if (ph == P_CFG) begin
         pre_left = l_pre;
         ph = (pre_left == 0) ? P_WAIT : P_PRE;
      end else if (ph >= P_PRE && ph <= P_POST && sample_en) begin
         a = m_ptr;
         e_wr_en = 1; e_wr_addr = a; e_wr_data = probe;
         m_ptr = (m_ptr + 1) % DEPTH;
         if (ph == P_PRE) begin
            pre_left--;
            if (pre_left == 0) ph = P_WAIT;
         end else if (ph == P_WAIT) begin
            if (((probe ^ l_val) & l_mask) == 0) begin
               e_trig = 1; e_taddr = a;
               e_start = ((a - l_pre) % DEPTH + DEPTH) % DEPTH;
               post_left = ((l_post < 1) ? 1 : l_post) - 1;
               ph = (post_left == 0) ? P_DONE : P_POST;
            end
         end else begin
            post_left--;
            if (post_left == 0) ph = P_DONE;
         end
      end
   endtask

   initial forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) model_reset();
      else model_step();
   end

   // Per-cycle compare against the model.
   int cyc = 0;
   int n_wr = 0;
   int wr_cyc[$];

   initial forever begin
      @(negedge clk);
      cyc++;
      if (wr_en === 1'b1) begin
         n_wr++;
         wr_cyc.push_back(cyc);
      end
      chk("wr_en", 32'(wr_en), 32'(e_wr_en));
      if (e_wr_en) begin
         chk("wr_addr", 32'(wr_addr), 32'(e_wr_addr));
         chk("wr_data", 32'(wr_data), 32'(e_wr_data));
      end
      chk("div_update", 32'(div_update), 32'(e_div_upd));
      chk("div_value", div_value, e_div_val);
      chk("busy", 32'(busy), 32'(ph >= P_CFG && ph <= P_POST));
      chk("done", 32'(done), 32'(ph == P_DONE));
      chk("triggered", 32'(triggered), 32'(e_trig));
      chk("trig_addr", 32'(trig_addr), 32'(e_taddr));
      chk("start_addr", 32'(start_addr), 32'(e_start));
   end

   // Divider stand-in and probe source: first strobe one cycle after div_update.
   int dper = 1, dcnt = 0, nstrobe = 0, thr = 1000;
   bit run = 0;
   int se_mode = 0;
   int pr_mode = 0;

   initial forever begin
      @(negedge clk);
      if (!resetn) begin
         run = 0; sample_en = 0;
      end else if (se_mode == 1) begin
         sample_en = ($urandom % 3 == 0);
      end else if (div_update === 1'b1) begin
         run = 1; dcnt = dper - 1; nstrobe = 0; sample_en = 0;
      end else if (run) begin
         dcnt++;
         if (dcnt >= dper) dcnt = 0;
         sample_en = (dcnt == 0);
      end else begin
         sample_en = 0;
      end
      if (sample_en) begin
         probe = (pr_mode == 1) ? 8'($urandom) : ((nstrobe >= thr) ? 8'h01 : 8'h00);
         nstrobe++;
      end
   end

   task automatic start_acq(input int div, input int pre, input int post,
                            input logic [7:0] mask, input logic [7:0] val);
      @(negedge clk);
      cfg_divider = 32'(div); cfg_pre = AW'(pre); cfg_post = AW'(post);
      cfg_trig_mask = mask; cfg_trig_val = val; dper = div;
      arm = 1;
      @(negedge clk);
      arm = 0;
   endtask

   task automatic wait_settle(input int budget, input string nm);
      int k = 0;
      while (busy === 1'b1 && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk({nm, "_timeout"}, 32'(busy), 32'(0));
   endtask

   initial begin
      #950000;
      $display("FAIL watchdog: simulation time limit reached");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      int n0;
      int k;
      repeat (3) @(negedge clk);
      resetn = 1;
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_wr_en", 32'(wr_en), 32'(0));

      // Scenario 1: trigger on probe[0] at sample 10.
      thr = 10; pr_mode = 0; se_mode = 0;
      start_acq(1, 4, 4, 8'h01, 8'h01);
      wait_settle(200, "t1");
      chk("t1_trig_addr", 32'(trig_addr), 32'd10);
      chk("t1_start_addr", 32'(start_addr), 32'd6);
      chk("t1_done", 32'(done), 32'd1);

      // Scenario 2: no pre window, mask 0, post 0 -> single write at address 0.
      n0 = n_wr;
      start_acq(1, 0, 0, 8'h00, 8'h00);
      wait_settle(200, "t2");
      repeat (2) @(negedge clk);
      chk("t2_writes", 32'(n_wr - n0), 32'd1);
      chk("t2_trig_addr", 32'(trig_addr), 32'd0);

      // Scenario 3: pointer wraps before the trigger.
      thr = 20;
      start_acq(1, 2, 3, 8'h01, 8'h01);
      wait_settle(200, "t3");
      chk("t3_trig_addr", 32'(trig_addr), 32'd4);
      chk("t3_start_addr", 32'(start_addr), 32'd2);

      // Scenario 4: abort while searching for the trigger.
      thr = 1000;
      start_acq(1, 0, 5, 8'hFF, 8'hFF);
      repeat (8) @(negedge clk);
      abort = 1;
      @(negedge clk);
      abort = 0;
      chk("t4_busy", 32'(busy), 32'd0);
      chk("t4_done", 32'(done), 32'd0);
      n0 = n_wr;
      repeat (20) @(negedge clk);
      chk("t4_no_writes", 32'(n_wr - n0), 32'd0);

      // Scenario 5: arm while busy is ignored; arm+abort from DONE goes idle.
      thr = 12;
      start_acq(1, 2, 4, 8'h01, 8'h01);
      repeat (4) @(negedge clk);
      cfg_divider = 32'd99; arm = 1;
      @(negedge clk);
      arm = 0;
      chk("t5_div_value", div_value, 32'd1);
      cfg_divider = 32'd1;
      wait_settle(200, "t5");
      chk("t5_done", 32'(done), 32'd1);
      @(negedge clk);
      arm = 1; abort = 1;
      @(negedge clk);
      arm = 0; abort = 0;
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_done_clr", 32'(done), 32'd0);

      // Scenario 6: slow divider spacing, then reset in the post window.
      n0 = n_wr;
      start_acq(270, 1, 5, 8'h00, 8'h00);
      k = 0;
      while ((n_wr - n0) < 3 && k < 2000) begin
         @(negedge clk);
         k++;
      end
      chk("t6_writes_seen", 32'((n_wr - n0) >= 3), 32'd1);
      if (wr_cyc.size() >= 3) begin
         chk("t6_spacing_a", 32'(wr_cyc[wr_cyc.size()-2] - wr_cyc[wr_cyc.size()-3]), 32'd270);
         chk("t6_spacing_b", 32'(wr_cyc[wr_cyc.size()-1] - wr_cyc[wr_cyc.size()-2]), 32'd270);
      end
      @(negedge clk);
      #2 resetn = 0;
      #1;
      chk("t6_rst_busy", 32'(busy), 32'd0);
      chk("t6_rst_trig", 32'(triggered), 32'd0);
      chk("t6_rst_wr_en", 32'(wr_en), 32'd0);
      chk("t6_rst_wr_addr", 32'(wr_addr), 32'd0);
      chk("t6_rst_wr_data", 32'(wr_data), 32'd0);
      chk("t6_rst_trig_addr", 32'(trig_addr), 32'd0);
      chk("t6_rst_start", 32'(start_addr), 32'd0);
      chk("t6_rst_div_value", div_value, 32'd0);
      chk("t6_rst_div_upd", 32'(div_update), 32'd0);
      chk("t6_rst_done", 32'(done), 32'd0);
      @(negedge clk);
      resetn = 1;

      // Randomized acquisitions with stray arm/abort pulses and irregular strobes.
      pr_mode = 1;
      for (int i = 0; i < 40; i++) begin
         se_mode = int'($urandom % 2);
         start_acq(int'($urandom_range(1, 3)), int'($urandom_range(0, 12)),
                   int'($urandom_range(0, 10)), 8'($urandom) & 8'h0F, 8'($urandom));
         k = 0;
         while (k < 1500) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            abort = ($urandom % 300 == 0);
            arm   = ($urandom % 40 == 0);
            k++;
         end
         arm = 0; abort = 0;
         chk("rnd_timeout", 32'(busy), 32'd0);
         repeat (int'($urandom_range(1, 4))) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
